// File: rtl/hilo_muldiv_unit_pkg.sv
// Shared encodings for the HI/LO multiply/divide unit: FSM states, HI/LO source
// select codes and the quotient reported for a divide by zero.
package hilo_muldiv_unit_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        MUL  = 2'b01,
        DIV  = 2'b10,
        FIX  = 2'b11
    } state_t;

    localparam logic [1:0] HILO_SRC_RS  = 2'b00;
    localparam logic [1:0] HILO_SRC_MUL = 2'b01;
    localparam logic [1:0] HILO_SRC_DIV = 2'b10;

    localparam logic [31:0] DIV_ZERO_Q = 32'hFFFF_FFFF;

endpackage

// File: rtl/hilo_muldiv_unit_div_core.sv
// Iterative unsigned restoring divider: one quotient bit per cycle, XLEN cycles
// after start. done is high during the final iteration cycle.
module div_core #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            done,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder
);

    localparam int CW = $clog2(XLEN);

    logic [XLEN-1:0] dvs;
    logic [CW-1:0]   cnt;
    logic            run;
    logic [XLEN:0]   trial;

    // Partial remainder shifted left with the next dividend bit, minus divisor.
    assign trial = {remainder, quotient[XLEN-1]} - {1'b0, dvs};
    assign done  = run && (cnt == CW'(XLEN-1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            quotient  <= '0;
            remainder <= '0;
            dvs       <= '0;
            cnt       <= '0;
            run       <= 1'b0;
        end else if (start) begin
            quotient  <= dividend;
            remainder <= '0;
            dvs       <= divisor;
            cnt       <= '0;
            run       <= 1'b1;
        end else if (run) begin
            if (trial[XLEN]) begin
                remainder <= {remainder[XLEN-2:0], quotient[XLEN-1]};
                quotient  <= {quotient[XLEN-2:0], 1'b0};
            end else begin
                remainder <= trial[XLEN-1:0];
                quotient  <= {quotient[XLEN-2:0], 1'b1};
            end
            cnt <= cnt + 1'b1;
            if (done) run <= 1'b0;
        end
    end

endmodule

// File: rtl/hilo_muldiv_unit.sv
// HI/LO owner beside the ALU: MULT/MULTU, DIV/DIVU and MTHI/MTLO, with a
// combinational stall while a multiply or divide is in flight.
module hilo_muldiv_unit
    import hilo_muldiv_unit_pkg::*;
#(
    parameter int MUL_LAT = 2,
    parameter int XLEN    = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [1:0]      hi_src,
    input  logic [1:0]      lo_src,
    input  logic            hi_w,
    input  logic            lo_w,
    input  logic            unsigned_in,
    input  logic            mf_hi,
    input  logic            mf_lo,
    input  logic [XLEN-1:0] rs_val,
    input  logic [XLEN-1:0] rt_val,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo,
    output logic            busy,
    output logic            stall,
    output logic            div_zero
);

    localparam int CW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

    state_t          state, state_nx;
    logic [CW-1:0]   mul_cnt;
    logic            req, accept, mul_last, div_start, div_done;
    logic [XLEN-1:0] op_a, op_b, dv_raw, a_mag, b_mag, q_fix, r_fix, quotient, remainder;
    logic            op_uns, neg_q, neg_r, dz;
    logic            a_neg, b_neg;
    logic [2*XLEN-1:0] mul_a_ext, mul_b_ext, product;
    logic            unused_lo_src;

    // Launch decisions key off hi_src alone; lo_src carries no extra information.
    assign unused_lo_src = ^lo_src;

    assign req      = hi_w | lo_w;
    assign accept   = (state == IDLE) && req;
    assign mul_last = (state == MUL) && (mul_cnt == CW'(MUL_LAT-1));

    // Low 2*XLEN bits of the sign-extended product equal the signed product.
    assign mul_a_ext = {{XLEN{~op_uns & op_a[XLEN-1]}}, op_a};
    assign mul_b_ext = {{XLEN{~op_uns & op_b[XLEN-1]}}, op_b};
    assign product   = mul_a_ext * mul_b_ext;

    assign a_neg = ~unsigned_in & rs_val[XLEN-1];
    assign b_neg = ~unsigned_in & rt_val[XLEN-1];
    assign a_mag = a_neg ? -rs_val : rs_val;
    assign b_mag = b_neg ? -rt_val : rt_val;
    assign q_fix = neg_q ? -quotient  : quotient;
    assign r_fix = neg_r ? -remainder : remainder;

    div_core #(.XLEN(XLEN)) u_div (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (div_start),
        .dividend  (a_mag),
        .divisor   (b_mag),
        .done      (div_done),
        .quotient  (quotient),
        .remainder (remainder)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (req) begin
                if (hi_src == HILO_SRC_MUL)      state_nx = MUL;
                else if (hi_src == HILO_SRC_DIV) state_nx = DIV;
            end
            MUL:  if (mul_last) state_nx = IDLE;
            DIV:  if (div_done) state_nx = FIX;
            FIX:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state != IDLE);
        stall     = busy & (req | mf_hi | mf_lo);
        div_start = accept && (hi_src == HILO_SRC_DIV);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi       <= '0;
            lo       <= '0;
            op_a     <= '0;
            op_b     <= '0;
            op_uns   <= 1'b0;
            mul_cnt  <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            dz       <= 1'b0;
            dv_raw   <= '0;
            div_zero <= 1'b0;
        end else begin
            div_zero <= 1'b0;
            if (accept) begin
                unique case (hi_src)
                    HILO_SRC_RS: begin
                        if (hi_w) hi <= rs_val;
                        if (lo_w) lo <= rs_val;
                    end
                    HILO_SRC_MUL: begin
                        op_a    <= rs_val;
                        op_b    <= rt_val;
                        op_uns  <= unsigned_in;
                        mul_cnt <= '0;
                    end
                    HILO_SRC_DIV: begin
                        neg_q  <= a_neg ^ b_neg;
                        neg_r  <= a_neg;
                        dz     <= (rt_val == '0);
                        dv_raw <= rs_val;
                    end
                    default: ;
                endcase
            end
            if (state == MUL) begin
                mul_cnt <= mul_cnt + 1'b1;
                if (mul_last) begin
                    hi <= product[2*XLEN-1:XLEN];
                    lo <= product[XLEN-1:0];
                end
            end
            if (state == FIX) begin
                if (dz) begin
                    lo       <= XLEN'(DIV_ZERO_Q);
                    hi       <= dv_raw;
                    div_zero <= 1'b1;
                end else begin
                    lo <= q_fix;
                    hi <= r_fix;
                end
            end
        end
    end

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Self-checking bench for hilo_muldiv_unit: directed and random MULT/DIV/MTxx
// traffic compared with an arithmetic model of HI/LO.
module tb_hilo_muldiv_unit;

    localparam int XLEN    = 32;
    localparam int MUL_LAT = 2;
    localparam int DIV_LAT = XLEN + 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  hi_src, lo_src;
    logic        hi_w, lo_w, unsigned_in, mf_hi, mf_lo;
    logic [31:0] rs_val, rt_val, hi, lo;
    logic        busy, stall, div_zero;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] exp_hi = '0;
    logic [31:0] exp_lo = '0;

    hilo_muldiv_unit #(.MUL_LAT(MUL_LAT), .XLEN(XLEN)) dut (
        .clk(clk), .rst_n(rst_n), .hi_src(hi_src), .lo_src(lo_src),
        .hi_w(hi_w), .lo_w(lo_w), .unsigned_in(unsigned_in),
        .mf_hi(mf_hi), .mf_lo(mf_lo), .rs_val(rs_val), .rt_val(rt_val),
        .hi(hi), .lo(lo), .busy(busy), .stall(stall), .div_zero(div_zero)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        hi_src = 2'b00; lo_src = 2'b00; hi_w = 1'b0; lo_w = 1'b0;
        unsigned_in = 1'b0; mf_hi = 1'b0; mf_lo = 1'b0;
        rs_val = '0; rt_val = '0;
    endtask

    // Reference arithmetic: 64-bit product and truncating division.
    function automatic void model_mul(input logic [31:0] a, input logic [31:0] b, input bit u,
                                      output logic [31:0] h, output logic [31:0] l);
        longint p;
        if (u) p = longint'({32'b0, a}) * longint'({32'b0, b});
        else   p = longint'(int'(a)) * longint'(int'(b));
        h = p[63:32];
        l = p[31:0];
    endfunction

    function automatic void model_div(input logic [31:0] a, input logic [31:0] b, input bit u,
                                      output logic [31:0] h, output logic [31:0] l);
        int sa, sb;
        if (b == 0) begin
            l = 32'hFFFF_FFFF; h = a;
        end else if (u) begin
            l = a / b; h = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            l = 32'h8000_0000; h = 0;
        end else begin
            sa = int'(a); sb = int'(b);
            l = 32'(sa / sb); h = 32'(sa % sb);
        end
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 6))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h0000_0001;
            default: return $urandom;
        endcase
    endfunction

    // Issue one instruction from IDLE, wait out busy, check latency and HI/LO.
    task automatic do_op(input string tag, input logic [1:0] src, input bit hw, input bit lw,
                         input bit uns, input logic [31:0] a, input logic [31:0] b);
        int cyc, want_cyc;
        logic [31:0] mh, ml;
        bit dz;
        want_cyc = (src == 2'b01) ? MUL_LAT : (src == 2'b10) ? DIV_LAT : 0;
        dz = (src == 2'b10) && (b == 0);
        case (src)
            2'b01: begin model_mul(a, b, uns, mh, ml); exp_hi = mh; exp_lo = ml; end
            2'b10: begin model_div(a, b, uns, mh, ml); exp_hi = mh; exp_lo = ml; end
            2'b00: begin if (hw) exp_hi = a; if (lw) exp_lo = a; end
            default: ;
        endcase
        hi_src = src; lo_src = src; hi_w = hw; lo_w = lw; unsigned_in = uns;
        rs_val = a; rt_val = b;
        #1;
        n_cmp++;
        if (stall !== 1'b0) begin n_err++; $display("FAIL %s idle_stall: got %b want 0", tag, stall); end
        tick();
        clear_in();
        cyc = 0;
        while (busy === 1'b1 && cyc < 200) begin
            tick();
            cyc++;
        end
        n_cmp++;
        if (cyc != want_cyc) begin n_err++; $display("FAIL %s busy_cycles: got %0d want %0d", tag, cyc, want_cyc); end
        n_cmp++;
        if (hi !== exp_hi) begin n_err++; $display("FAIL %s hi: got %h want %h (a=%h b=%h u=%0d)", tag, hi, exp_hi, a, b, uns); end
        n_cmp++;
        if (lo !== exp_lo) begin n_err++; $display("FAIL %s lo: got %h want %h (a=%h b=%h u=%0d)", tag, lo, exp_lo, a, b, uns); end
        n_cmp++;
        if (div_zero !== dz) begin n_err++; $display("FAIL %s div_zero: got %b want %b", tag, div_zero, dz); end
        tick();
        n_cmp++;
        if (div_zero !== 1'b0) begin n_err++; $display("FAIL %s div_zero_pulse: got %b want 0", tag, div_zero); end
    endtask

    task automatic test_reset();
        clear_in();
        rst_n = 1'b0;
        tick(); tick();
        n_cmp++;
        if ({hi, lo} !== 64'h0) begin n_err++; $display("FAIL reset_hilo: got %h_%h want 0_0", hi, lo); end
        n_cmp++;
        if ({busy, stall, div_zero} !== 3'b000) begin n_err++; $display("FAIL reset_flags: got %b want 000", {busy, stall, div_zero}); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_mthi_mtlo();
        do_op("mthi", 2'b00, 1'b1, 1'b0, 1'b0, 32'hA5A5_A5A5, 32'h0);
        do_op("mtlo", 2'b00, 1'b0, 1'b1, 1'b0, 32'h5A5A_5A5A, 32'h0);
        do_op("mthilo", 2'b00, 1'b1, 1'b1, 1'b0, 32'h1357_9BDF, 32'h0);
        do_op("nop11", 2'b11, 1'b1, 1'b1, 1'b0, 32'hDEAD_BEEF, 32'h1);
    endtask

    task automatic test_mul();
        do_op("mult", 2'b01, 1'b1, 1'b1, 1'b0, 32'hFFFF_FFFE, 32'd3);
        do_op("multu", 2'b01, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFE, 32'd3);
        for (int i = 0; i < 8; i++)
            do_op("mul_rnd", 2'b01, 1'b1, 1'b1, 1'($urandom_range(0, 1)), pick(), pick());
    endtask

    task automatic test_div();
        do_op("div", 2'b10, 1'b1, 1'b1, 1'b0, 32'hFFFF_FFF9, 32'd2);
        do_op("divu", 2'b10, 1'b1, 1'b1, 1'b1, 32'd7, 32'd2);
        do_op("div_ovf", 2'b10, 1'b1, 1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
        do_op("div_zero", 2'b10, 1'b1, 1'b1, 1'b0, 32'h1234_5678, 32'h0);
        do_op("divu_zero", 2'b10, 1'b1, 1'b1, 1'b1, 32'h8765_4321, 32'h0);
        for (int i = 0; i < 6; i++)
            do_op("div_rnd", 2'b10, 1'b1, 1'b1, 1'($urandom_range(0, 1)), pick(), pick());
    endtask

    task automatic test_mf_stall();
        int cyc;
        logic [31:0] mh, ml;
        model_mul(32'h0001_2345, 32'hFFFF_0010, 1'b0, mh, ml);
        hi_src = 2'b01; lo_src = 2'b01; hi_w = 1'b1; lo_w = 1'b1;
        rs_val = 32'h0001_2345; rt_val = 32'hFFFF_0010;
        tick();
        clear_in();
        mf_lo = 1'b1;
        cyc = 0;
        while (busy === 1'b1 && cyc < 200) begin
            n_cmp++;
            if (stall !== 1'b1) begin n_err++; $display("FAIL mf_lo_stall: got %b want 1 at cycle %0d", stall, cyc); end
            tick();
            cyc++;
        end
        exp_hi = mh; exp_lo = ml;
        n_cmp++;
        if (cyc != MUL_LAT) begin n_err++; $display("FAIL mf_busy_cycles: got %0d want %0d", cyc, MUL_LAT); end
        n_cmp++;
        if (stall !== 1'b0) begin n_err++; $display("FAIL mf_lo_release: got %b want 0", stall); end
        n_cmp++;
        if (lo !== exp_lo) begin n_err++; $display("FAIL mf_lo_value: got %h want %h", lo, exp_lo); end
        mf_lo = 1'b0; mf_hi = 1'b1;
        #1;
        n_cmp++;
        if (stall !== 1'b0) begin n_err++; $display("FAIL mf_hi_idle_stall: got %b want 0", stall); end
        clear_in();
        tick();
    endtask

    // Divide in flight with a second request held behind it.
    task automatic test_held_behind_div(input string tag, input logic [1:0] src2,
                                        input logic [31:0] a2, input logic [31:0] b2);
        int cyc, want2;
        logic [31:0] dh, dl, mh, ml, old_hi, old_lo;
        model_div(32'hFFFF_FF00, 32'd7, 1'b0, dh, dl);
        old_hi = exp_hi; old_lo = exp_lo;
        hi_src = 2'b10; lo_src = 2'b10; hi_w = 1'b1; lo_w = 1'b1;
        rs_val = 32'hFFFF_FF00; rt_val = 32'd7;
        tick();
        hi_src = src2; lo_src = src2; hi_w = 1'b1; lo_w = (src2 != 2'b00);
        unsigned_in = 1'b0; rs_val = a2; rt_val = b2;
        cyc = 0;
        while (busy === 1'b1 && cyc < 200) begin
            #1;
            n_cmp++;
            if (stall !== 1'b1 || hi !== old_hi || lo !== old_lo) begin
                n_err++;
                $display("FAIL %s held: stall=%b hi=%h lo=%h want stall=1 hi=%h lo=%h", tag, stall, hi, lo, old_hi, old_lo);
            end
            tick();
            cyc++;
        end
        n_cmp++;
        if (cyc != DIV_LAT) begin n_err++; $display("FAIL %s div_cycles: got %0d want %0d", tag, cyc, DIV_LAT); end
        n_cmp++;
        if (hi !== dh || lo !== dl || stall !== 1'b0) begin
            n_err++;
            $display("FAIL %s div_result: hi=%h lo=%h stall=%b want hi=%h lo=%h stall=0", tag, hi, lo, stall, dh, dl);
        end
        tick();
        clear_in();
        if (src2 == 2'b00) begin
            exp_hi = a2; exp_lo = dl; want2 = 0;
        end else begin
            model_mul(a2, b2, 1'b0, mh, ml);
            exp_hi = mh; exp_lo = ml; want2 = MUL_LAT;
        end
        cyc = 0;
        while (busy === 1'b1 && cyc < 200) begin
            tick();
            cyc++;
        end
        n_cmp++;
        if (cyc != want2) begin n_err++; $display("FAIL %s second_cycles: got %0d want %0d", tag, cyc, want2); end
        n_cmp++;
        if (hi !== exp_hi || lo !== exp_lo) begin
            n_err++;
            $display("FAIL %s second_result: hi=%h lo=%h want hi=%h lo=%h", tag, hi, lo, exp_hi, exp_lo);
        end
        tick();
    endtask

    task automatic test_reset_mid_div();
        do_op("pre_mt", 2'b00, 1'b1, 1'b1, 1'b0, 32'hCAFE_F00D, 32'h0);
        hi_src = 2'b10; lo_src = 2'b10; hi_w = 1'b1; lo_w = 1'b1;
        rs_val = 32'h7FFF_0000; rt_val = 32'd3;
        tick();
        clear_in();
        repeat (9) tick();
        n_cmp++;
        if (busy !== 1'b1) begin n_err++; $display("FAIL rst_mid_busy_before: got %b want 1", busy); end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
            n_err++;
            $display("FAIL rst_mid_div: busy=%b hi=%h lo=%h want busy=0 hi=0 lo=0", busy, hi, lo);
        end
        exp_hi = '0; exp_lo = '0;
        tick();
        rst_n = 1'b1;
        tick();
        do_op("mult_after_rst", 2'b01, 1'b1, 1'b1, 1'b0, 32'hFFFF_FFFE, 32'd3);
    endtask

    task automatic test_random();
        logic [1:0] src;
        bit hw, lw;
        for (int i = 0; i < 30; i++) begin
            src = 2'($urandom_range(0, 3));
            hw = 1'($urandom_range(0, 1));
            lw = 1'($urandom_range(0, 1));
            if (!hw && !lw) hw = 1'b1;
            do_op("rand", src, hw, lw, 1'($urandom_range(0, 1)), pick(), pick());
        end
    endtask

    initial begin
        clear_in();
        test_reset();
        test_mthi_mtlo();
        test_mul();
        test_div();
        test_mf_stall();
        test_held_behind_div("mthi_during_div", 2'b00, 32'h0BAD_CAFE, 32'h0);
        test_held_behind_div("back_to_back", 2'b01, 32'h8000_0001, 32'hFFFF_FFFD);
        test_reset_mid_div();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
